// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared lane-select encodings and sweep state type for regfile_sb.
//  Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam logic [2:0] PPP_FULL  = 3'b000;
    localparam logic [2:0] PPP_UPPER = 3'b001;
    localparam logic [2:0] PPP_LOWER = 3'b010;
    localparam logic [2:0] PPP_ODDB  = 3'b011;
    localparam logic [2:0] PPP_EVENB = 3'b100;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_ppp_decode.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_ppp_decode
//  Purpose  : Maps a lane-select code to a per-byte write mask and legal flag.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_ppp_decode
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]          i_ppp,
    output logic [DATA_W/8-1:0] o_byte_mask,
    output logic                o_legal
);

    localparam int c_nbytes = DATA_W / 8;

    always_comb begin
        o_byte_mask = '0;
        o_legal     = 1'b1;
        for (int i = 0; i < c_nbytes; i++) begin
            case (i_ppp)
                PPP_FULL:  o_byte_mask[i] = 1'b1;
                PPP_UPPER: o_byte_mask[i] = (i >= c_nbytes / 2);
                PPP_LOWER: o_byte_mask[i] = (i < c_nbytes / 2);
                PPP_ODDB:  o_byte_mask[i] = ((i % 2) == 1);
                PPP_EVENB: o_byte_mask[i] = ((i % 2) == 0);
                default: begin
                    o_byte_mask[i] = 1'b0;
                    o_legal        = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Byte-lane register file with write bypass, pending-write
//             scoreboard and a post-reset clearing sweep.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     read_address1,
    input  logic [AW-1:0]     read_address2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic              busy1,
    output logic              busy2,
    input  logic              writen_en,
    input  logic [AW-1:0]     write_address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        ppp,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_address,
    output logic              ready,
    output logic              err_ppp
);

    localparam int            c_nbytes   = DATA_W / 8;
    localparam logic [AW-1:0] c_last_idx = AW'(NREGS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [AW-1:0]       r_clr_idx;
    logic [DATA_W-1:0]   r_mem [NREGS];
    logic [NREGS-1:0]    r_busy;
    logic [NREGS-1:0]    w_busy_next;
    logic                r_err_ppp;

    logic [c_nbytes-1:0] w_byte_mask;
    logic                w_ppp_legal;
    logic                w_ready;
    logic                w_wb_hit;
    logic                w_wr_do;
    logic                w_issue;
    logic [DATA_W-1:0]   w_wr_data;

    regfile_ppp_decode #(
        .DATA_W (DATA_W)
    ) u_ppp_decode (
        .i_ppp       (ppp),
        .o_byte_mask (w_byte_mask),
        .o_legal     (w_ppp_legal)
    );

    assign w_ready  = (r_state == RUN);
    // A writeback clears its scoreboard bit even when the lane code is illegal
    assign w_wb_hit = writen_en && w_ready && (write_address != '0);
    assign w_wr_do  = w_wb_hit && w_ppp_legal;
    assign w_issue  = issue_en && w_ready && (issue_address != '0);
    assign ready    = w_ready;
    assign err_ppp  = r_err_ppp;

    always_comb begin
        w_wr_data = r_mem[write_address];
        for (int i = 0; i < c_nbytes; i++) begin
            if (w_byte_mask[i]) begin
                w_wr_data[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_idx <= r_clr_idx + AW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (r_clr_idx == c_last_idx) w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else if (w_wr_do) begin
                r_mem[write_address] <= w_wr_data;
            end
        end
    end

    // Set after clear so a same-cycle issue wins over the writeback
    always_comb begin
        w_busy_next = r_busy;
        if (w_wb_hit) w_busy_next[write_address] = 1'b0;
        if (w_issue)  w_busy_next[issue_address] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy    <= '0;
            r_err_ppp <= 1'b0;
        end else begin
            r_busy    <= w_busy_next;
            r_err_ppp <= w_wb_hit && !w_ppp_legal;
        end
    end

    always_comb begin
        data_out1 = '0;
        data_out2 = '0;
        if (w_ready && (read_address1 != '0)) begin
            data_out1 = (w_wr_do && (write_address == read_address1)) ? w_wr_data : r_mem[read_address1];
        end
        if (w_ready && (read_address2 != '0)) begin
            data_out2 = (w_wr_do && (write_address == read_address2)) ? w_wr_data : r_mem[read_address2];
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        if (read_address1 != '0) begin
            busy1 = (w_wb_hit && (write_address == read_address1) &&
                     !(w_issue && (issue_address == read_address1))) ? 1'b0 : r_busy[read_address1];
        end
        if (read_address2 != '0) begin
            busy2 = (w_wb_hit && (write_address == read_address2) &&
                     !(w_issue && (issue_address == read_address2))) ? 1'b0 : r_busy[read_address2];
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register width in bits; legal values are multiples of 16.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values are powers of 2, at least 4.
REQ-003 SHALL have parameter AW, default $clog2(NREGS), address width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 SHALL have port read_address1 / read_address2, input, AW bits each: read port addresses.
REQ-007 SHALL have port data_out1 / data_out2, output, DATA_W bits each: read data.
REQ-008 SHALL have port busy1 / busy2, output, 1 bit each: scoreboard pending-write flag of read_address1 / read_address2.
REQ-009 SHALL have port writen_en, input, 1 bit: writeback enable.
REQ-010 SHALL have port write_address, input, AW bits: writeback target register.
REQ-011 SHALL have port data_in, input, DATA_W bits: writeback data.
REQ-012 SHALL have port ppp, input, 3 bits: lane participation select.
REQ-013 SHALL have port issue_en, input, 1 bit: marks a destination register pending.
REQ-014 SHALL have port issue_address, input, AW bits: destination register to mark pending.
REQ-015 SHALL have port ready, output, 1 bit: high when the clear sweep is done and the block accepts operations.
REQ-016 SHALL have port err_ppp, output, 1 bit: registered one-cycle pulse flagging an illegal ppp on an accepted write.

Function
REQ-017 Byte i SHALL be bits [8i+7:8i]; the ppp byte mask SHALL be: 000 all bytes; 001 upper DATA_W/2; 010 lower DATA_W/2; 011 odd-index bytes; 100 even-index bytes.
REQ-018 An accepted write (writen_en=1, ready=1, write_address!=0, legal ppp) SHALL update only the masked bytes at the rising edge; unmasked bytes SHALL hold.
REQ-019 A write with ppp in 101..111 SHALL change no register and SHALL assert err_ppp in the next cycle for exactly one cycle.
REQ-020 Register 0 SHALL always read 0; writes to it SHALL be ignored, with no err_ppp pulse.
REQ-021 Reads SHALL be combinational; when an accepted write targets the read address, data_outN SHALL equal stored data with masked bytes replaced by data_in (byte-accurate bypass).
REQ-022 busy[a] SHALL set at the edge of issue_en with issue_address=a (a!=0, ready=1).
REQ-023 busy[a] SHALL clear at the edge of an accepted writeback to a, regardless of ppp legality.
REQ-024 When issue and writeback hit the same address in one cycle, busy SHALL end set (issue wins).
REQ-025 busyN SHALL be combinational: 0 when an accepted writeback to read_addressN is present this cycle and no same-address issue is present; otherwise busy[read_addressN]; always 0 for address 0.
REQ-026 State machine SHALL be CLEAR -> RUN; CLEAR SHALL write zero to entry clr_idx each cycle, clr_idx running 0..NREGS-1; CLEAR SHALL enter RUN after the entry NREGS-1 write.
REQ-027 In CLEAR, ready SHALL be 0, writes and issues SHALL be ignored, and data_outN SHALL be 0.
REQ-028 ready SHALL be high in RUN only.

Reset
REQ-029 reset_n=0 at an edge SHALL enter CLEAR with clr_idx=0, all busy bits 0, and err_ppp 0; this SHALL also apply when reset occurs mid-sweep, which restarts the sweep.
REQ-030 After release, ready SHALL rise exactly NREGS cycles after the first edge at which reset_n=1.

Structure
REQ-031 Package regfile_pkg SHALL hold the ppp encodings (PPP_FULL, PPP_UPPER, PPP_LOWER, PPP_ODDB, PPP_EVENB) and the state typedef {CLEAR, RUN}.
REQ-032 Sub-module regfile_ppp_decode SHALL be combinational, mapping ppp to a DATA_W/8 byte mask and a legal flag; it SHALL be used for the write path and for the bypass.

Verification
REQ-033 Reset: hold reset_n low for 3 cycles, then release -> ready=0 for 32 cycles then 1; every register reads 0; err_ppp is 0.
REQ-034 Lane writes to r5: write 0x1111..11 with ppp=000, then 0xAABBCCDDEEFF0011 with ppp=011 -> r5 reads 0xAA11CC11EE110011; a same-cycle read shows the bypassed value.
REQ-035 Illegal ppp: write r7 with ppp=110 -> r7 unchanged and err_ppp high for one cycle; busy[7] cleared if previously set.
REQ-036 Scoreboard: issue r3 -> busy1=1 for read_address1=3; writeback r3 -> busy1=0 in the same cycle; issue and writeback of r3 together -> busy stays 1.
REQ-037 Reset asserted at clr_idx=10 -> sweep restarts; ready rises 32 cycles after release; issue_en and writes during CLEAR have no effect.
REQ-038 Parametrisation: DATA_W=128, NREGS=8 -> ppp=001 writes bits [127:64]; ready rises 8 cycles after release.
